// File: rtl/trig_issue_scheduler.sv
// Round-robin issue of sin/cos ops from NUM_REQ requesters onto one shared fixed-latency trig pipeline pair.
// Optional macro TRIG_SCHED_PERF_EN adds perf_issued / perf_stall counters.
module trig_issue_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned LATENCY    = 147,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_op,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [31:0]           trig_in,
  input  logic [31:0]           trig_sin,
  input  logic [31:0]           trig_cos,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_op,
  output logic [31:0]           rsp_data
`ifdef TRIG_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_stall
`endif
);

  // Stage 0 is loaded together with trig_in; stage LATENCY lines up with the unit outputs.
  localparam int unsigned TAG_DEPTH = LATENCY + 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            op;
  } tag_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            op;
    logic [31:0]     data;
  } rsp_t;

  logic               active;
  logic [ID_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]   credits;
  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    gnt_id;
  logic               sel_op;
  logic [31:0]        sel_data;
  logic               accept;
  logic               push;
  logic               pop;
  tag_t               issue_tag;
  tag_t               tag_line [TAG_DEPTH];
  rsp_t               mem [FIFO_DEPTH];
  rsp_t               head;
  rsp_t               push_entry;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [CNT_W-1:0]   fifo_cnt_nxt;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    logic found;
    grant_c = '0;
    gnt_id  = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (i == (32'(rr_ptr) + k) % NUM_REQ)) begin
          grant_c[i] = 1'b1;
          gnt_id     = ID_W'(i);
          found      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_op   = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        sel_op   = req_op[i];
        sel_data = req_data[32*i +: 32];
      end
    end
  end

  // active keeps req_ready low while reset is held and for the first cycle after release.
  assign req_ready = (active && (credits != '0)) ? grant_c : '0;
  assign accept    = |req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    issue_tag       = '0;
    issue_tag.valid = accept;
    issue_tag.id    = gnt_id;
    issue_tag.op    = sel_op;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active  <= 1'b0;
      rr_ptr  <= '0;
      credits <= CNT_W'(FIFO_DEPTH);
      trig_in <= '0;
    end else begin
      active <= 1'b1;
      if (accept) begin
        trig_in <= sel_data;
        rr_ptr  <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end
      if (accept && !pop) begin
        credits <= credits - CNT_W'(1);
      end else if (!accept && pop) begin
        credits <= credits + CNT_W'(1);
      end
    end
  end

  // Tag delay line; bubbles shift in whenever nothing is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
        tag_line[i] <= '0;
      end
    end else begin
      tag_line[0] <= issue_tag;
      for (int unsigned i = 1; i < TAG_DEPTH; i++) begin
        tag_line[i] <= tag_line[i-1];
      end
    end
  end

  assign push = tag_line[TAG_DEPTH-1].valid;

  always_comb begin
    push_entry      = '0;
    push_entry.id   = tag_line[TAG_DEPTH-1].id;
    push_entry.op   = tag_line[TAG_DEPTH-1].op;
    push_entry.data = tag_line[TAG_DEPTH-1].op ? trig_cos : trig_sin;
  end

  // Result storage is data-only; occupancy is tracked by the reset pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (push && !pop) begin
      fifo_cnt_nxt = fifo_cnt + CNT_W'(1);
    end else if (!push && pop) begin
      fifo_cnt_nxt = fifo_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_cnt  <= fifo_cnt_nxt;
      rsp_valid <= (fifo_cnt_nxt != '0);
    end
  end

  // Show-ahead head; zeroed while empty so the stale storage never leaks out.
  assign head     = mem[rd_ptr];
  assign rsp_id   = rsp_valid ? head.id   : '0;
  assign rsp_op   = rsp_valid ? head.op   : 1'b0;
  assign rsp_data = rsp_valid ? head.data : '0;

  a_fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(push && !pop && (fifo_cnt == CNT_W'(FIFO_DEPTH))));

`ifdef TRIG_SCHED_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if ((|req_valid) && (credits == '0)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_trig_issue_scheduler.sv
// Randomized bench for trig_issue_scheduler with behavioural Sin/Cos pipelines and an issue-order scoreboard.
module tb_trig_issue_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int LATENCY    = 147;
  localparam int FIFO_DEPTH = 16;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_op = '0;
  logic [NUM_REQ*32-1:0] req_data = '0;
  logic [31:0]           trig_in;
  logic [31:0]           trig_sin;
  logic [31:0]           trig_cos;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_op;
  logic [31:0]           rsp_data;
`ifdef TRIG_SCHED_PERF_EN
  logic [31:0]           perf_issued;
  logic [31:0]           perf_stall;
`endif

  always #5 clock = ~clock;

  trig_issue_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .trig_in(trig_in), .trig_sin(trig_sin), .trig_cos(trig_cos),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_op(rsp_op),
    .rsp_data(rsp_data)
`ifdef TRIG_SCHED_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input real obs, input real exp, input real tol = 0.0);
    checks++;
    if ((obs - exp > tol) || (exp - obs > tol)) begin
      errors++;
      $display("FAIL %s observed=%0.10g expected=%0.10g", tag, obs, exp);
    end
  endtask

  // float32 <-> real helpers (normal numbers and zero only)
  function automatic real f2d(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] d2f(input real r);
    logic [63:0] b;
    b = $realtobits(r);
    if (b[62:52] < 11'd897) return 32'd0;
    return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
  endfunction

  // Behavioural Sin/Cos units: output follows trig_in LATENCY clocks later.
  logic [31:0] pipe [LATENCY];
  always @(posedge clock) begin
    pipe[0] <= trig_in;
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign trig_sin = d2f($sin(f2d(pipe[LATENCY-1])));
  assign trig_cos = d2f($cos(f2d(pipe[LATENCY-1])));

  typedef struct {
    int          id;
    bit          op;
    logic [31:0] angle;
  } op_t;

  // Scoreboard / model state, owned by the monitor.
  op_t  exp_q[$];
  int   gl[$];
  int   ptr_m = 0;
  int   warm = 0;
  int   stall_m = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  int   rise_cyc = 0;
  int   n_acc = 0;
  int   rsp_seen = 0;
  int   acc_cnt [NUM_REQ] = '{default: 0};
  logic [NUM_REQ-1:0] exp_ready;
  bit   prev_valid = 0;
  bit   stalled = 0;
  logic [ID_W-1:0] s_id;
  logic s_op;
  logic [31:0] s_data;
  int   last_id = 0;
  bit   last_op = 0;
  logic [31:0] last_data = '0;
  op_t  e;
  int   j;

  // Stimulus controls, owned by the main sequence.
  int   target [NUM_REQ] = '{default: 0};
  int   p_valid = 100;
  bit   use_fixed = 0;
  bit   fixed_op = 0;
  logic [31:0] fixed_data = '0;
  int   rsp_mode = 0;
  int   pulse_req = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: samples on the falling edge what the next rising edge will do.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_q.delete();
        ptr_m = 0; warm = 0; stall_m = 0; stalled = 0; prev_valid = 0;
      end else begin
        exp_ready = '0;
        if (warm >= 1 && exp_q.size() < FIFO_DEPTH) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            j = (ptr_m + k) % NUM_REQ;
            if (exp_ready == '0 && req_valid[j]) exp_ready[j] = 1'b1;
          end
        end
        check("req_ready", req_ready, exp_ready);
        if ((|req_valid) && exp_q.size() == FIFO_DEPTH) stall_m++;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            e.id = i; e.op = req_op[i]; e.angle = req_data[32*i +: 32];
            exp_q.push_back(e);
            gl.push_back(i);
            ptr_m = (i + 1) % NUM_REQ;
            acc_cnt[i]++;
            n_acc++;
            acc_edge = cyc + 1;
          end
        end
        if (rsp_valid) begin
          if (!prev_valid) rise_cyc = cyc;
          if (stalled) begin
            check("stall_id", rsp_id, s_id);
            check("stall_op", rsp_op, s_op);
            check("stall_data", rsp_data, s_data);
          end
          check("rsp_pending", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 1);
          if (rsp_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_op", rsp_op, e.op);
            check("rsp_data", f2d(rsp_data),
                  e.op ? $cos(f2d(e.angle)) : $sin(f2d(e.angle)), 1.0e-4);
            rsp_seen++;
            last_id = rsp_id; last_op = rsp_op; last_data = rsp_data;
          end
        end
        stalled = rsp_valid && !rsp_ready;
        s_id = rsp_id; s_op = rsp_op; s_data = rsp_data;
        prev_valid = rsp_valid;
        warm++;
      end
    end
  end

  // Requester / response-side driver.
  int acc_seen [NUM_REQ] = '{default: 0};
  int pulse_done = 0;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_seen[i] != acc_cnt[i]) begin
          acc_seen[i] = acc_cnt[i];
          req_valid[i] = 1'b0;
        end
        if (!reset) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && acc_cnt[i] < target[i] && $urandom_range(99) < p_valid) begin
          req_valid[i] = 1'b1;
          req_op[i] = use_fixed ? fixed_op : 1'($urandom_range(1));
          req_data[32*i +: 32] = use_fixed ? fixed_data :
            d2f(($itor($urandom_range(60000)) - 30000.0) / 10000.0);
        end
      end
      if (pulse_done != pulse_req) begin
        pulse_done = pulse_req;
        rsp_ready = 1'b1;
      end else begin
        case (rsp_mode)
          1:       rsp_ready = 1'b1;
          2:       rsp_ready = ~rsp_ready;
          default: rsp_ready = 1'b0;
        endcase
      end
    end
  end

  function automatic bit idle();
    for (int i = 0; i < NUM_REQ; i++) if (acc_cnt[i] < target[i]) return 0;
    return (req_valid == '0) && (exp_q.size() == 0) && !rsp_valid;
  endfunction

  task automatic wait_drain(input string tag, input int limit);
    bit done;
    done = 0;
    for (int n = 0; n < limit && !done; n++) begin
      @(posedge clock);
      #2;
      done = idle();
    end
    check(tag, done, 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, req_ready, 0);
    check({pfx, "_trig_in"}, trig_in, 0);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_id"}, rsp_id, 0);
    check({pfx, "_rsp_op"}, rsp_op, 0);
    check({pfx, "_rsp_data"}, rsp_data, 0);
  endtask

  initial begin
    int s;
    int n0;
    int cnt;
    bit done;

    // Power-on reset
    #2;
    check_reset_outputs("por");
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;

    // Single cos(0) op, latency and exact value
    rsp_mode = 1; use_fixed = 1; fixed_op = 1; fixed_data = 32'h0; p_valid = 100;
    target[0] = acc_cnt[0] + 1;
    wait_drain("single_drain", 400);
    check("single_latency", rise_cyc - acc_edge, LATENCY + 1);
    check("single_id", last_id, 0);
    check("single_op", last_op, 1);
    check("single_data", last_data, 32'h3f800000);
    use_fixed = 0;

    // Fairness: all requesters continuously valid
    s = gl.size();
    for (int i = 0; i < NUM_REQ; i++) target[i] = acc_cnt[i] + 12;
    wait_drain("fair_drain", 800);
    check("fair_count", gl.size() - s, 12 * NUM_REQ);
    for (int k = s + 1; k < gl.size(); k++) check("fair_order", gl[k], (gl[k-1] + 1) % NUM_REQ);

    // Backpressure: rsp_ready toggling, random request pattern
    n0 = rsp_seen;
    rsp_mode = 2; p_valid = 60;
    for (int i = 0; i < NUM_REQ; i++) target[i] = acc_cnt[i] + 16;
    wait_drain("bp_drain", 3000);
    check("bp_count", rsp_seen - n0, 64);

    // Reset in the middle of operation
    rsp_mode = 1; p_valid = 100;
    target[1] = acc_cnt[1] + 10;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(posedge clock);
      #2;
      done = (acc_cnt[1] >= target[1]);
    end
    check("rst_issue10", done, 1);
    repeat (50) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clock);
      #2;
      if (rsp_valid) cnt++;
    end
    check("rst_no_rsp", cnt, 0);

    // Credits: no pops, stream requests on requester 2
    rsp_mode = 0;
    n0 = n_acc;
    target[2] = acc_cnt[2] + 20;
    repeat (200) @(posedge clock);
    #2;
    check("credit_accepts", n_acc - n0, FIFO_DEPTH);
    check("credit_ready", req_ready, 0);
`ifdef TRIG_SCHED_PERF_EN
    check("perf_issued", perf_issued, FIFO_DEPTH);
    check("perf_stall", perf_stall, stall_m);
`endif
    pulse_req++;
    repeat (30) @(posedge clock);
    #2;
    check("credit_one_more", n_acc - n0, FIFO_DEPTH + 1);
    rsp_mode = 1;
    wait_drain("credit_drain", 1000);
    check("credit_total", n_acc - n0, 20);
`ifdef TRIG_SCHED_PERF_EN
    check("perf_issued_end", perf_issued, 20);
    check("perf_stall_end", perf_stall, stall_m);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
